// File: rtl/vipvfr_timing_pkg.sv
// Shared constants for the VIP raster timing counters.
// No logic; widths and field encodings only.
// Not applicable: no flow control.
package vipvfr_timing_pkg;
    localparam int   H_WIDTH_DEF = 14;
    localparam int   V_WIDTH_DEF = 13;
    localparam logic FIELD_0     = 1'b0;
    localparam logic FIELD_1     = 1'b1;
endpackage

// File: rtl/alt_vipvfr131_common_plane_sequencer.sv
// Colour-plane sequencer: tracks which plane of a sample is on the bus.
// Latency: sample_ticks registered, start/count strobes combinational.
// Backpressure: enable low holds the plane index; sclr returns it to plane 0.
module alt_vipvfr131_common_plane_sequencer #(
    parameter int NUMBER_OF_COLOUR_PLANES       = 3,
    parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 1,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES  = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    sclr,
    input  logic                                    enable,
    output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks,
    output logic                                    start_of_sample,
    output logic                                    count_sample
);
    localparam int LW = LOG2_NUMBER_OF_COLOUR_PLANES;
    localparam logic [LW-1:0] LAST_PLANE = LW'(NUMBER_OF_COLOUR_PLANES - 1);
    localparam logic [LW-1:0] TICK_ONE   = LW'(1);
    localparam bit PARALLEL = (COLOUR_PLANES_ARE_IN_PARALLEL != 0);

    logic last_plane;

    // In parallel mode every enabled cycle is a whole sample, so the index never leaves 0.
    assign last_plane      = PARALLEL || (sample_ticks == LAST_PLANE);
    assign start_of_sample = PARALLEL || (sample_ticks == '0);
    assign count_sample    = enable && last_plane;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_ticks <= '0;
        end else if (sclr) begin
            sample_ticks <= '0;
        end else if (enable) begin
            if (last_plane) begin
                sample_ticks <= '0;
            end else begin
                sample_ticks <= sample_ticks + TICK_ONE;
            end
        end
    end
endmodule

// File: rtl/alt_vipvfr131_common_timing_counter.sv
// Raster timing counter: horizontal sample, line-in-field and field position.
// Latency: counters registered; strobes and active window combinational off them.
// Backpressure: enable low freezes all state and silences strobes; sclr preloads.
module alt_vipvfr131_common_timing_counter
    import vipvfr_timing_pkg::*;
#(
    parameter int H_WIDTH                       = H_WIDTH_DEF,
    parameter int V_WIDTH                       = V_WIDTH_DEF,
    parameter int NUMBER_OF_COLOUR_PLANES       = 3,
    parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 1,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES  = 2,
    parameter int TOTALS_MINUS_ONE              = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    sclr,
    input  logic                                    enable,
    input  logic                                    interlaced,
    input  logic [H_WIDTH-1:0]                      h_total,
    input  logic [V_WIDTH-1:0]                      v_total_f0,
    input  logic [V_WIDTH-1:0]                      v_total_f1,
    input  logic [H_WIDTH-1:0]                      h_reset,
    input  logic [V_WIDTH-1:0]                      v_reset,
    input  logic                                    field_reset,
    input  logic [H_WIDTH-1:0]                      h_active_start,
    input  logic [H_WIDTH-1:0]                      h_active_end,
    input  logic [V_WIDTH-1:0]                      v_active_start,
    input  logic [V_WIDTH-1:0]                      v_active_end,
    output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks,
    output logic                                    start_of_sample,
    output logic                                    count_sample,
    output logic [H_WIDTH-1:0]                      h_count,
    output logic [V_WIDTH-1:0]                      v_count,
    output logic                                    field,
    output logic                                    new_line,
    output logic                                    end_of_field,
    output logic                                    end_of_frame,
    output logic                                    active
);
    localparam logic [H_WIDTH-1:0] H_ONE = H_WIDTH'(1);
    localparam logic [V_WIDTH-1:0] V_ONE = V_WIDTH'(1);

    logic [H_WIDTH-1:0] h_lim;
    logic [V_WIDTH-1:0] v_total_sel;
    logic [V_WIDTH-1:0] v_lim;

    alt_vipvfr131_common_plane_sequencer #(
        .NUMBER_OF_COLOUR_PLANES      (NUMBER_OF_COLOUR_PLANES),
        .COLOUR_PLANES_ARE_IN_PARALLEL(COLOUR_PLANES_ARE_IN_PARALLEL),
        .LOG2_NUMBER_OF_COLOUR_PLANES (LOG2_NUMBER_OF_COLOUR_PLANES)
    ) u_plane_seq (
        .clk            (clk),
        .rst            (rst),
        .sclr           (sclr),
        .enable         (enable),
        .sample_ticks   (sample_ticks),
        .start_of_sample(start_of_sample),
        .count_sample   (count_sample)
    );

    // The limit follows the field being counted, not the interlaced flag, so a
    // field in progress when interlacing is switched off still uses its own height.
    assign v_total_sel = (field == FIELD_1) ? v_total_f1 : v_total_f0;
    assign h_lim = (TOTALS_MINUS_ONE != 0) ? h_total     : h_total - H_ONE;
    assign v_lim = (TOTALS_MINUS_ONE != 0) ? v_total_sel : v_total_sel - V_ONE;

    // >= rather than == so a total reprogrammed below the count wraps at once.
    assign new_line     = !sclr && count_sample && (h_count >= h_lim);
    assign end_of_field = new_line && (v_count >= v_lim);
    assign end_of_frame = end_of_field && (!interlaced || (field == FIELD_1));

    assign active = (h_count >= h_active_start) && (h_count < h_active_end) &&
                    (v_count >= v_active_start) && (v_count < v_active_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
            field   <= FIELD_0;
        end else if (sclr) begin
            h_count <= h_reset;
            v_count <= v_reset;
            field   <= field_reset && interlaced;
        end else if (new_line) begin
            h_count <= '0;
            if (end_of_field) begin
                v_count <= '0;
                field   <= interlaced ? ~field : FIELD_0;
            end else begin
                v_count <= v_count + V_ONE;
            end
        end else if (count_sample) begin
            h_count <= h_count + H_ONE;
        end
    end
endmodule

// File: doc/alt_vipvfr131_common_timing_counter.md
Name: alt_vipvfr131_common_timing_counter

Overview:
- Parametrised raster timing counter for the VIP frame-reader/clocked-video paths. Tracks the horizontal sample position, vertical line position and interlaced field of a video raster.
- Generalises the fixed 14/13-bit frame counter:
  - configurable counter widths;
  - in-block colour-plane sample sequencing;
  - run-time interlaced (two-field) support with independent field heights;
  - end-of-field/end-of-frame strobes and an active-picture window flag.
- Sits between the control-register slave and the sync/video-data generators.

Parameters:
- H_WIDTH, 14, width of h_count and all horizontal totals/limits.
- V_WIDTH, 13, width of v_count and all vertical totals/limits.
- NUMBER_OF_COLOUR_PLANES, 3, planes per sample; legal range 1..16.
- COLOUR_PLANES_ARE_IN_PARALLEL, 1, 1 = one sample per enabled cycle; 0 = one sample per NUMBER_OF_COLOUR_PLANES enabled cycles.
- LOG2_NUMBER_OF_COLOUR_PLANES, 2, width of sample_ticks; minimum 1.
- TOTALS_MINUS_ONE, 0, 1 = totals inputs already hold total-1; 0 = block subtracts 1 (modulo 2^width).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- sclr  in  1  synchronous clear/preload; has priority over enable
- enable  in  1  advance one cycle of the raster
- interlaced  in  1  1 = alternate field 0/field 1; 0 = progressive
- h_total  in  H_WIDTH  samples per line
- v_total_f0  in  V_WIDTH  lines in field 0, or the whole frame when progressive
- v_total_f1  in  V_WIDTH  lines in field 1; ignored when interlaced=0
- h_reset  in  H_WIDTH  preload value for h_count on sclr
- v_reset  in  V_WIDTH  preload value for v_count on sclr
- field_reset  in  1  preload value for field on sclr
- h_active_start, h_active_end  in  H_WIDTH  active window, half-open [start, end)
- v_active_start, v_active_end  in  V_WIDTH  active window, half-open [start, end)
- sample_ticks  out  LOG2_NUMBER_OF_COLOUR_PLANES  plane index within the current sample
- start_of_sample  out  1  current cycle is plane 0 of a sample
- count_sample  out  1  current cycle completes a sample
- h_count  out  H_WIDTH  registered horizontal position
- v_count  out  V_WIDTH  registered line within the current field
- field  out  1  registered current field
- new_line  out  1  last sample of a line is completing
- end_of_field  out  1  last sample of a field is completing
- end_of_frame  out  1  last sample of a frame is completing
- active  out  1  current position lies inside both active windows

Behaviour:
- Reset (rst high, asynchronous): h_count=0, v_count=0, field=0, sample_ticks=0.
- Sample sequencing:
  - Parallel mode: sample_ticks is held at 0; start_of_sample=1; count_sample=enable.
  - Sequential mode: sample_ticks increments on each enabled cycle and wraps to 0 after NUMBER_OF_COLOUR_PLANES-1.
  - start_of_sample = (sample_ticks==0).
  - count_sample = enable && (sample_ticks==NUMBER_OF_COLOUR_PLANES-1).
- Internal limits:
  - h_lim = h_total-1, or h_total when TOTALS_MINUS_ONE=1.
  - v_lim = (field ? v_total_f1 : v_total_f0), minus 1 unless TOTALS_MINUS_ONE=1.
  - Arithmetic is modulo 2^width. A total of 0 with TOTALS_MINUS_ONE=0 gives an all-ones limit; this is legal and must not hang the counter.
- Combinational strobes, each with zero latency from the counters:
  - new_line = count_sample && (h_count >= h_lim).
  - end_of_field = new_line && (v_count >= v_lim).
  - end_of_frame = end_of_field && (!interlaced || field).
- Update priority, per cycle: sclr > enable > hold.
- sclr:
  - h_count<=h_reset, v_count<=v_reset, field<=field_reset && interlaced, sample_ticks<=0.
  - All strobes are forced to 0 during the sclr cycle.
- enable with new_line:
  - h_count<=0.
  - If end_of_field: v_count<=0 and field<=interlaced ? ~field : 0.
  - Otherwise v_count<=v_count+1.
- enable with count_sample and no new_line: h_count<=h_count+1.
- enable low: all state and sample_ticks hold; all strobes are 0.
- The >= comparisons mean that if totals are reprogrammed below the current count, the counter wraps at the next sample. It never runs to 2^width.
- interlaced dropping to 0 mid-field: the current field completes using the current field's total. field is then forced to 0.
- Registered state changes take effect on the clock edge following the enabled cycle.
- active = (h_active_start <= h_count < h_active_end) && (v_active_start <= v_count < v_active_end).
  - active is combinational from the registered counters.
  - An empty window (start >= end) gives active=0.

Decomposition:
- Shared package/include vipvfr_timing_pkg holds:
  - default widths H_WIDTH_DEF=14 and V_WIDTH_DEF=13;
  - field encoding constants FIELD_0=0 and FIELD_1=1.
- One sub-module, alt_vipvfr131_common_plane_sequencer: sample_ticks, start_of_sample and count_sample logic.
- Line, field and window logic stays in the top level.

Test Plan:
- Parallel, h_total=4, v_total_f0=3, interlaced=0, enable=1 → h_count 0,1,2,3,0…; new_line on every h_count=3; end_of_frame on (h=3, v=2) every 12 cycles.
- Sequential, 3 planes, h_total=2, enable=1 → sample_ticks 0,1,2,0…; h_count advances every 3 cycles; new_line on cycle 6.
- Interlaced, v_total_f0=3, v_total_f1=2, h_total=2 → end_of_field after 6 then 4 samples; field toggles; end_of_frame only at the end of field 1 (every 10 samples).
- sclr with h_reset=5, v_reset=7, field_reset=1, interlaced=1 while counting, enable=1 → next cycle h=5, v=7, field=1, ticks=0; sclr overrides enable; no strobes in the sclr cycle.
- Reprogram h_total from 100 to 10 while h_count=50 → new_line on the next count_sample; h_count=0 afterwards.
- Window h_active=[2,5), v_active=[1,2) on a 6x3 raster; assert rst mid-frame → active asserted exactly on h 2..4 of line 1; on rst all counters read 0 immediately, without waiting for a clock edge.
